rx_frame_check: RTL and testbench
=================================

// Module: rx_frame_check
// PURPOSE
//  Parametrised UART RX frame checker: start-glitch, parity and stop checks plus LSB-first data capture.
//  Sits in UART_RX beside the edge/bit counter and data sampler. Consumes sampled_bit at each
//  sample strobe. Tracks frame position with its own FSM.
//  Reports per-frame errors and a validated parallel word to the RX controller.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (5..9)
//  PRESC_W     6  width of edge_cnt / PRESCALE
//  STOP_BITS   1  stop bits checked per frame (1 or 2)
//  ERR_CNT_W   8  width of each error counter (ERR_CNT_EN only)
// PORTS
//  CLK          in   1           clock
//  RST          in   1           async active-low reset
//  frm_start    in   1           1-cycle pulse: falling edge detected, frame begins
//  sampled_bit  in   1           majority-voted bit from the sampler
//  edge_cnt     in   PRESC_W     oversampling edge counter
//  PRESCALE     in   PRESC_W     strobe compare value
//  PAR_EN       in   1           parity bit present
//  PAR_TYP      in   1           0 = even, 1 = odd
//  err_cnt_clr  in   1           synchronous clear of error counters
//  busy         out  1           FSM not in IDLE
//  strt_glitch  out  1           start bit sampled high
//  par_err      out  1           parity mismatch
//  stp_err      out  1           a stop bit sampled low
//  frame_done   out  1           1-cycle pulse: frame finished (not issued on a glitch abort)
//  data_valid   out  1           1-cycle pulse with frame_done when par_err=0 and stp_err=0
//  p_data       out  DATA_WIDTH  captured word; updated only on data_valid
//  glitch_cnt   out  ERR_CNT_W   start glitches seen
//  par_err_cnt  out  ERR_CNT_W   parity errors seen
//  stp_err_cnt  out  ERR_CNT_W   stop errors seen
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = IDLE; shift register and parity accumulator = 0.
//  - Strobe stb = (edge_cnt == PRESCALE). All checks and shifts happen only on stb.
//  - frm_start in IDLE:
//      go START; clear strt_glitch, par_err and stp_err;
//      latch PAR_EN/PAR_TYP (mid-frame changes ignored).
//  - frm_start outside IDLE: ignored.
//  - START @stb:
//      sampled_bit=1 -> strt_glitch<=1, go IDLE (abort, no frame_done);
//      sampled_bit=0 -> go DATA, bit_idx=0, acc=0.
//  - DATA @stb:
//      shift sampled_bit in LSB-first; acc ^= sampled_bit.
//      At bit_idx==DATA_WIDTH-1, go PARITY if latched PAR_EN, else go STOP.
//  - PARITY @stb:
//      par_err <= (sampled_bit != acc^PAR_TYP); go STOP, stop_idx=0.
//  - STOP @stb:
//      sampled_bit=0 -> stp_err<=1 (sticky within the frame).
//      At stop_idx==STOP_BITS-1, go IDLE and next cycle pulse frame_done.
//      data_valid/p_data use error state including this final bit.
//  - Error flags are levels: held until the next accepted frm_start.
//  - busy=1 from the cycle after an accepted frm_start until the FSM returns to IDLE.
//  - frame_done latency: 1 CLK after the last stop-bit strobe.
//  - Reset mid-frame: immediate return to reset values; partial data is discarded.
// CONFIGURATION
//  Macro RX_ERR_CNT_EN.
//  Defined:
//    - Each counter +1 in the cycle its flag is set; saturates at all-ones.
//    - err_cnt_clr zeroes all three counters and wins over a simultaneous increment.
//  Undefined:
//    - Counter logic is not synthesised; the three *_cnt ports are tied to 0.
//    - err_cnt_clr is ignored.
// TESTING
//  1. DATA_WIDTH=8, PAR_EN=0, frame 0x A5 with good stop
//       -> frame_done=1, data_valid=1, p_data=8'hA5, all errs 0.
//  2. PAR_EN=1, PAR_TYP=0, data 0x03, parity bit 1
//       -> par_err=1, data_valid=0, p_data keeps its previous value.
//  3. start bit sampled 1 at stb
//       -> strt_glitch=1, busy=0 next cycle, no frame_done; a later good frame clears strt_glitch.
//  4. STOP_BITS=2, 2nd stop bit 0
//       -> stp_err=1, frame_done=1, data_valid=0.
//  5. RST low during DATA bit 4
//       -> all outputs 0, busy=0; next frame 0x5A captured correctly.
//  6. RX_ERR_CNT_EN, ERR_CNT_W=2, 5 glitch frames
//       -> glitch_cnt saturates at 3; err_cnt_clr with a 6th glitch -> glitch_cnt=0.

Source files
------------

// File: rtl/rx_frame_check.sv
// rtl/rx_frame_check.sv - UART RX frame checker: start glitch, parity, stop checks and LSB-first capture.
// Optional error counters are enabled by defining RX_ERR_CNT_EN.
module rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int STOP_BITS  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frm_start,
  input  logic                  sampled_bit,
  input  logic [PRESC_W-1:0]    edge_cnt,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  err_cnt_clr,
  output logic                  busy,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic [ERR_CNT_W-1:0]  glitch_cnt,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
  output logic [ERR_CNT_W-1:0]  stp_err_cnt
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  acc_q, acc_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  glitch_q, glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  stb;

  assign stb = (edge_cnt == PRESCALE);

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    pen_d      = pen_q;
    ptyp_d     = ptyp_q;
    glitch_d   = glitch_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    done_d     = 1'b0;
    valid_d    = 1'b0;
    p_data_d   = p_data_q;
    case (state_q)
      S_IDLE: begin
        if (frm_start) begin
          state_d   = S_START;
          glitch_d  = 1'b0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
          pen_d     = PAR_EN;
          ptyp_d    = PAR_TYP;
        end
      end
      S_START: begin
        if (stb) begin
          if (sampled_bit) begin
            glitch_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            acc_d     = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (stb) begin
          // Shift in at the MSB so the first received bit ends up at bit 0.
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          acc_d     = acc_q ^ sampled_bit;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            state_d    = pen_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (stb) begin
          par_err_d  = (sampled_bit != (acc_q ^ ptyp_q));
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (stb) begin
          if (!sampled_bit) stp_err_d = 1'b1;
          if (stop_idx_q == LAST_STOP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            valid_d = !par_err_d && !stp_err_d;
            if (valid_d) p_data_d = shift_q;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      glitch_q   <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      p_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      pen_q      <= pen_d;
      ptyp_q     <= ptyp_d;
      glitch_q   <= glitch_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      p_data_q   <= p_data_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign strt_glitch = glitch_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign frame_done  = done_q;
  assign data_valid  = valid_q;
  assign p_data      = p_data_q;

`ifdef RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] glitch_cnt_q, par_cnt_q, stp_cnt_q;
  logic                 glitch_inc, par_inc, stp_inc;

  // Count flag rising edges so a sticky flag is counted once per frame.
  assign glitch_inc = glitch_d  & ~glitch_q;
  assign par_inc    = par_err_d & ~par_err_q;
  assign stp_inc    = stp_err_d & ~stp_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      glitch_cnt_q <= '0;
      par_cnt_q    <= '0;
      stp_cnt_q    <= '0;
    end else if (err_cnt_clr) begin
      glitch_cnt_q <= '0;
      par_cnt_q    <= '0;
      stp_cnt_q    <= '0;
    end else begin
      if (glitch_inc && !(&glitch_cnt_q)) glitch_cnt_q <= glitch_cnt_q + 1'b1;
      if (par_inc && !(&par_cnt_q))       par_cnt_q    <= par_cnt_q + 1'b1;
      if (stp_inc && !(&stp_cnt_q))       stp_cnt_q    <= stp_cnt_q + 1'b1;
    end
  end

  assign glitch_cnt  = glitch_cnt_q;
  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = err_cnt_clr;
  assign glitch_cnt  = '0;
  assign par_err_cnt = '0;
  assign stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_frame_check.sv
// tb/tb_rx_frame_check.sv - scoreboard bench for rx_frame_check (STOP_BITS=2, ERR_CNT_W=2).
module tb_rx_frame_check;
  localparam int DW = 8;
  localparam int PW = 6;
  localparam int SB = 2;
  localparam int EW = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          frm_start = 1'b0;
  logic          sampled_bit = 1'b1;
  logic [PW-1:0] edge_cnt = '0;
  logic [PW-1:0] PRESCALE = 6'd3;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          err_cnt_clr = 1'b0;
  logic          busy, strt_glitch, par_err, stp_err, frame_done, data_valid;
  logic [DW-1:0] p_data;
  logic [EW-1:0] glitch_cnt, par_err_cnt, stp_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard entry: {frame_done, data_valid, par_err, stp_err, strt_glitch, p_data}
  logic [DW+4:0] exp_q[$];
  logic [DW+4:0] exp_v;
  logic [DW+4:0] obs_v;
  logic [DW-1:0] exp_pdata = '0;

  rx_frame_check #(.DATA_WIDTH(DW), .PRESC_W(PW), .STOP_BITS(SB), .ERR_CNT_W(EW)) dut (
    .CLK(CLK), .RST(RST), .frm_start(frm_start), .sampled_bit(sampled_bit),
    .edge_cnt(edge_cnt), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .err_cnt_clr(err_cnt_clr), .busy(busy), .strt_glitch(strt_glitch), .par_err(par_err),
    .stp_err(stp_err), .frame_done(frame_done), .data_valid(data_valid), .p_data(p_data),
    .glitch_cnt(glitch_cnt), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  assign obs_v = {frame_done, data_valid, par_err, stp_err, strt_glitch, p_data};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    for (int e = 0; e <= int'(PRESCALE); e++) begin
      edge_cnt    = PW'(e);
      sampled_bit = b;
      tick();
    end
    edge_cnt    = '0;
    sampled_bit = 1'b1;
  endtask

  task automatic start_frame(input logic pen, input logic ptyp);
    PAR_EN    = pen;
    PAR_TYP   = ptyp;
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    // Flip the config mid-frame; the DUT must keep the latched values.
    PAR_EN  = ~pen;
    PAR_TYP = ~ptyp;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic s1, input logic s2);
    logic p, perr, serr, val;
    perr = pen & bad_par;
    serr = !(s1 & s2);
    val  = !perr && !serr;
    if (val) exp_pdata = d;
    exp_q.push_back({1'b1, val, perr, serr, 1'b0, exp_pdata});
    p = (^d) ^ ptyp ^ bad_par;
    start_frame(pen, ptyp);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (pen) send_bit(p);
    send_bit(s1);
    send_bit(s2);
  endtask

  task automatic test_reset();
    vectors++;
    if ({obs_v, busy, glitch_cnt, par_err_cnt, stp_err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h busy=%b cnts=%h/%h/%h, want all 0",
               obs_v, busy, glitch_cnt, par_err_cnt, stp_err_cnt);
    end
  endtask

  task automatic test_good_frames();
    logic [DW-1:0] tbl_d[3] = '{8'hA5, 8'h3C, 8'h81};
    logic          tbl_p[3] = '{1'b0, 1'b1, 1'b1};
    logic          tbl_t[3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      send_frame(tbl_d[k], tbl_p[k], tbl_t[k], 1'b0, 1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL good_frame[%0d]: got %h want %h", k, obs_v, exp_v);
      end
      tick();
      vectors++;
      if ({frame_done, data_valid, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL pulse_end[%0d]: got done/valid/busy=%b want 000", k,
                 {frame_done, data_valid, busy});
      end
    end
  endtask

  task automatic test_parity_err();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL parity_err: got %h want %h", obs_v, exp_v);
    end
    tick();
  endtask

  task automatic test_glitch();
    start_frame(1'b0, 1'b0);
    send_bit(1'b1);
    vectors++;
    if ({strt_glitch, busy, frame_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL glitch_abort: got glitch/busy/done=%b want 100", {strt_glitch, busy, frame_done});
    end
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen_done |= frame_done;
      end
      vectors++;
      if (seen_done !== 1'b0 || strt_glitch !== 1'b1) begin
        miscompares++;
        $display("FAIL glitch_hold: got done_seen=%b glitch=%b want 0 1", seen_done, strt_glitch);
      end
    end
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL glitch_clear: got %h want %h", obs_v, exp_v);
    end
    tick();
  endtask

  task automatic test_stop_err();
    logic s1_tbl[3] = '{1'b1, 1'b0, 1'b0};
    logic s2_tbl[3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      send_frame(8'h77 + 8'(k), 1'b0, 1'b0, 1'b0, s1_tbl[k], s2_tbl[k]);
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL stop_err[%0d]: got %h want %h", k, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'b1, 1'($urandom_range(0, 3) != 0));
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h want %h", k, obs_v, exp_v);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    start_frame(1'b0, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    edge_cnt    = 6'd1;
    sampled_bit = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    vectors++;
    if ({obs_v, busy, glitch_cnt, par_err_cnt, stp_err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got %h busy=%b cnts=%h/%h/%h want all 0",
               obs_v, busy, glitch_cnt, par_err_cnt, stp_err_cnt);
    end
    edge_cnt  = '0;
    exp_pdata = '0;
    tick();
    RST = 1'b1;
    tick();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL after_reset_frame: got %h want %h", obs_v, exp_v);
    end
    tick();
  endtask

  task automatic test_err_counters();
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
`ifdef RX_ERR_CNT_EN
    vectors++;
    if ({glitch_cnt, par_err_cnt, stp_err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL cnt_clear: got %h/%h/%h want 0", glitch_cnt, par_err_cnt, stp_err_cnt);
    end
    for (int k = 1; k <= 5; k++) begin
      start_frame(1'b0, 1'b0);
      send_bit(1'b1);
      vectors++;
      if (glitch_cnt !== EW'((k > 3) ? 3 : k)) begin
        miscompares++;
        $display("FAIL glitch_cnt[%0d]: got %0d want %0d", k, glitch_cnt, (k > 3) ? 3 : k);
      end
    end
    start_frame(1'b0, 1'b0);
    err_cnt_clr = 1'b1;
    send_bit(1'b1);
    err_cnt_clr = 1'b0;
    vectors++;
    if ({glitch_cnt, strt_glitch} !== {EW'(0), 1'b1}) begin
      miscompares++;
      $display("FAIL clr_wins: got cnt=%0d glitch=%b want 0 1", glitch_cnt, strt_glitch);
    end
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    vectors++;
    if ({obs_v, par_err_cnt, stp_err_cnt} !== {exp_v, EW'(1), EW'(1)}) begin
      miscompares++;
      $display("FAIL par_stp_cnt: got %h cnt=%0d/%0d want %h 1/1", obs_v, par_err_cnt, stp_err_cnt, exp_v);
    end
`else
    start_frame(1'b0, 1'b0);
    send_bit(1'b1);
    vectors++;
    if ({glitch_cnt, par_err_cnt, stp_err_cnt, strt_glitch} !== {EW'(0), EW'(0), EW'(0), 1'b1}) begin
      miscompares++;
      $display("FAIL cnt_tied: got %h/%h/%h glitch=%b want 0 0 0 1",
               glitch_cnt, par_err_cnt, stp_err_cnt, strt_glitch);
    end
`endif
    tick();
  endtask

  initial begin
    RST = 1'b0;
    tick();
    tick();
    test_reset();
    RST = 1'b1;
    tick();
    test_good_frames();
    test_parity_err();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_err_counters();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
